// File: rtl/msk_unloader_pkg.sv
// Shared types and sizing helpers for the masked share unloader.
package msk_unloader_pkg;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  function automatic int beats_f(input int count, input int w);
    return count / w;
  endfunction

  // Beat counter width: clog2(BEATS), never narrower than one bit.
  function automatic int cnt_w_f(input int count, input int w);
    int b;
    b = count / w;
    return (b > 1) ? $clog2(b) : 1;
  endfunction

endpackage

// File: rtl/msk_share_shift_reg.sv
// Masked block register: load, per-share shift by W with zero fill, or hold.
// Each share slice has its own mux and register, so shares never share a cone.
module msk_share_shift_reg
  import msk_unloader_pkg::*;
#(
  parameter int D     = 2,
  parameter int COUNT = 128,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_load,
  input  logic                       i_shift,
  input  logic [D-1:0][COUNT-1:0]    i_data,
  output logic [D-1:0][W-1:0]        o_beat
);

  for (genvar j = 0; j < D; j++) begin : g_share
    logic [COUNT-1:0] w_shifted;
    logic [COUNT-1:0] w_next;
    logic [COUNT-1:0] r_sh;

    if (COUNT > W) begin : g_shift
      assign w_shifted = {{W{1'b0}}, r_sh[COUNT-1:W]};
    end else begin : g_noshift
      assign w_shifted = '0;
    end

    // Selects are public handshakes only; data inputs are this share alone.
    always_comb begin
      w_next = r_sh;
      if (i_load)       w_next = i_data[j];
      else if (i_shift) w_next = w_shifted;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                r_sh <= '0;
      else if (i_load | i_shift) r_sh <= w_next;
    end

    assign o_beat[j] = r_sh[W-1:0];
  end

endmodule

// File: rtl/msk_share_unloader.sv
// Streams one masked block out as count/W beats of W sharings, never unmasking.
// Define MSK_UNLOADER_OVERLAP_EN to accept the next block during the last beat.
module msk_share_unloader
  import msk_unloader_pkg::*;
#(
  parameter int d     = 2,
  parameter int count = 128,
  parameter int W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [count*d-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W*d-1:0]       out_data,
  output logic                 out_last
);

  localparam int BEATS = beats_f(count, W);
  localparam int CW    = cnt_w_f(count, W);
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  if (count % W != 0) begin : g_bad_cfg
    $error("msk_share_unloader: count must be a multiple of W");
  end

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_out_valid;
  logic            r_out_last;
  logic            w_last;
  logic            w_accept;
  logic            w_fire;

  assign w_last = (r_cnt == LAST_CNT);

`ifdef MSK_UNLOADER_OVERLAP_EN
  assign in_ready = (r_state == IDLE) | ((r_state == SEND) & w_last & out_ready);
`else
  assign in_ready = (r_state == IDLE);
`endif

  assign w_accept  = in_valid & in_ready;
  assign w_fire    = r_out_valid & out_ready;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_state     <= SEND;
          r_cnt       <= '0;
          r_out_valid <= 1'b1;
          r_out_last  <= (BEATS == 1);
        end
        SEND: if (out_ready) begin
          // An overlapped accept replaces the drained remains and restarts the block.
          if (w_accept) begin
            r_cnt      <= '0;
            r_out_last <= (BEATS == 1);
          end else if (w_last) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
          end else begin
            r_cnt      <= r_cnt + 1'b1;
            r_out_last <= ((r_cnt + 1'b1) == LAST_CNT);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  msk_share_shift_reg #(.D(d), .COUNT(count), .W(W)) u_sreg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_accept),
    .i_shift (w_fire),
    .i_data  (in_data),
    .o_beat  (out_data)
  );

endmodule

// File: tb/tb_msk_share_unloader.sv
// Self-checking bench for msk_share_unloader (d=2, count=128, W=32).
module tb_msk_share_unloader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic         out_last;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  msk_share_unloader #(.d(2), .count(128), .W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct { logic [127:0] s0; logic [127:0] s1; logic [63:0] b0; logic [63:0] b3; } vec_t;
  typedef struct { logic [63:0] data; logic last; } beat_t;

  vec_t  vt[3];
  beat_t sb[$];
  beat_t mon_e;
  beat_t mon_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Scoreboard: expected beats pushed at accept, popped at each output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
        else begin
          mon_e = sb.pop_front();
          chk("sb_data", out_data, mon_e.data);
          chk("sb_last", {63'd0, out_last}, {63'd0, mon_e.last});
        end
      end
      if (in_valid && in_ready)
        for (int b = 0; b < 4; b++) begin
          mon_t.data = {in_data[128 + b*32 +: 32], in_data[b*32 +: 32]};
          mon_t.last = (b == 3);
          sb.push_back(mon_t);
        end
    end
  end

  task automatic accept_block(input logic [127:0] s0, input logic [127:0] s1);
    bit ok = 0;
    in_data  = {s1, s0};
    in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic get_beat(output logic [63:0] d, output logic l, output int waits);
    waits = 0; d = '0; l = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      waits++;
      if (out_valid && out_ready) begin d = out_data; l = out_last; return; end
    end
    chk("beat_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (!out_valid && sb.size() == 0) break;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  logic [2:0]  tr_ctl[2][12];
  logic [63:0] tr_dat[2][12];
  bit          orp[13] = '{1,1,1,0,1,0,0,1,1,1,1,1,1};

  task automatic run_trace(input int r, input logic [127:0] s1);
    in_data   = {s1, vt[0].s0};
    in_valid  = 1'b1;
    out_ready = orp[0];
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      tr_ctl[r][c] = {in_ready, out_valid, out_last};
      tr_dat[r][c] = out_data;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = orp[c+1];
    end
    out_ready = 1'b1;
    drain();
  endtask

  logic [63:0] bd;
  logic        bl;
  int          bw;
  logic        e_rdy, e_vld, e_lst;
  int          b_c;

  initial begin
    vt[0] = '{128'h0F0E0D0C_0B0A0908_07060504_03020100, {128{1'b1}},
              {32'hFFFFFFFF, 32'h03020100}, {32'hFFFFFFFF, 32'h0F0E0D0C}};
    vt[1] = '{128'h0, 128'h11111111_22222222_33333333_44444444,
              {32'h44444444, 32'h0}, {32'h11111111, 32'h0}};
    vt[2] = '{128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF, 128'h0,
              {32'h0, 32'h89ABCDEF}, {32'h0, 32'hDEADBEEF}};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    #1;
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_last",  {63'd0, out_last},  64'd0);
    chk("rst_out_data",  out_data,           64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ordering: table of blocks, beat0 and beat3 against constants.
    foreach (vt[v]) begin
      accept_block(vt[v].s0, vt[v].s1);
      get_beat(bd, bl, bw);
      if (v == 0) chk("first_beat_latency", 64'(bw), 64'd1);
      chk("tbl_beat0", bd, vt[v].b0);
      chk("tbl_beat0_last", {63'd0, bl}, 64'd0);
      get_beat(bd, bl, bw);
      get_beat(bd, bl, bw);
      get_beat(bd, bl, bw);
      chk("tbl_beat3", bd, vt[v].b3);
      chk("tbl_beat3_last", {63'd0, bl}, 64'd1);
    end
    drain();

    // Backpressure at beat1 for five cycles.
    accept_block(vt[0].s0, vt[0].s1);
    get_beat(bd, bl, bw);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_data",  out_data, {32'hFFFFFFFF, 32'h07060504});
      chk("stall_last",  {63'd0, out_last}, 64'd0);
      chk("stall_cnt",   64'(dut.r_cnt), 64'd1);
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    get_beat(bd, bl, bw);
    chk("resume_beat1", bd, {32'hFFFFFFFF, 32'h07060504});
    get_beat(bd, bl, bw);
    chk("beat2_wait", 64'(bw), 64'd1);
    chk("beat2_data", bd, {32'hFFFFFFFF, 32'h0B0A0908});
    drain();

    // Busy input and back-to-back timing, in_valid held high.
`ifdef MSK_UNLOADER_OVERLAP_EN
    b_c = 5;
`else
    b_c = 6;
`endif
    in_data  = {vt[0].s1, vt[0].s0};
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
`ifdef MSK_UNLOADER_OVERLAP_EN
      e_rdy = (c == 0 || c == 4 || c == 8);
      e_vld = (c >= 1);
      e_lst = (c == 4 || c == 8);
`else
      e_rdy = (c == 0 || c == 5);
      e_vld = (c != 0 && c != 5);
      e_lst = (c == 4 || c == 9);
`endif
      @(negedge clk);
      chk($sformatf("b2b_in_ready_c%0d", c),  {63'd0, in_ready},  {63'd0, e_rdy});
      chk($sformatf("b2b_out_valid_c%0d", c), {63'd0, out_valid}, {63'd0, e_vld});
      chk($sformatf("b2b_out_last_c%0d", c),  {63'd0, out_last},  {63'd0, e_lst});
      if (c == b_c) chk("b2b_second_beat0", out_data, vt[2].b0);
      @(posedge clk); #1;
      if (c == 0) in_data = {vt[2].s1, vt[2].s0};
      if (c == 9) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    drain();

    // Reset after the beat1 handshake drops the block.
    accept_block(vt[0].s0, vt[0].s1);
    get_beat(bd, bl, bw);
    get_beat(bd, bl, bw);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_out_last",  {63'd0, out_last},  64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", {63'd0, in_ready},  64'd1);
    chk("postrst_no_beat",  {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    accept_block(vt[1].s0, vt[1].s1);
    get_beat(bd, bl, bw);
    chk("postrst_beat0", bd, vt[1].b0);
    drain();

    // Hygiene: flipping share1 only changes share-1 output bits.
    run_trace(0, vt[0].s1);
    run_trace(1, ~vt[0].s1);
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("leak_ctl_c%0d", c), 64'(tr_ctl[1][c]), 64'(tr_ctl[0][c]));
      chk($sformatf("leak_sh0_c%0d", c), 64'(tr_dat[1][c][31:0]), 64'(tr_dat[0][c][31:0]));
      if (tr_ctl[0][c][1])
        chk($sformatf("leak_sh1_c%0d", c), 64'(tr_dat[1][c][63:32] ^ tr_dat[0][c][63:32]),
            64'hFFFFFFFF);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
